// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation sequencer: FSM states,
// preset select codes and the watchdog counter width.
package irrig_pkg;

  localparam int WDOG_W = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'b00,
    SEL_DRIP  = 2'b01,
    SEL_SPRAY = 2'b10,
    SEL_SPEC  = 2'b11
  } sel_t;

  // Mode arbitration: specific program beats sprinkler beats drip.
  function automatic sel_t pick_mode(input logic drip, input logic spray, input logic spec);
    if (spec)       return SEL_SPEC;
    else if (spray) return SEL_SPRAY;
    else if (drip)  return SEL_DRIP;
    return SEL_NONE;
  endfunction

endpackage

// File: rtl/irrigation_sequencer_if.sv
// Field-side bundle of the irrigation sequencer: buttons/sensors in,
// timer strobes, actuator drives and status out.
interface irrigation_sequencer_if;

  logic       tick_1s;
  logic       start_btn;
  logic       stop_btn;
  logic       req_drip;
  logic       req_spray;
  logic       req_spec;
  logic       water_ok;
  logic       timer_zero;

  logic       cnt_load;
  logic       cnt_clear;
  logic [1:0] cnt_sel;
  logic       cnt_en;
  logic       valve_drip;
  logic       valve_spray;
  logic       pump;
  logic       busy;
  logic       done;
  logic       fault;

  modport master (
    output tick_1s, start_btn, stop_btn, req_drip, req_spray, req_spec,
           water_ok, timer_zero,
    input  cnt_load, cnt_clear, cnt_sel, cnt_en, valve_drip, valve_spray,
           pump, busy, done, fault
  );

  modport slave (
    input  tick_1s, start_btn, stop_btn, req_drip, req_spray, req_spec,
           water_ok, timer_zero,
    output cnt_load, cnt_clear, cnt_sel, cnt_en, valve_drip, valve_spray,
           pump, busy, done, fault
  );

endinterface

// File: rtl/irrig_sec_counter.sv
// Tick-driven up counter with synchronous clear, saturation at all-ones
// and an equality flag against a fixed target.
module irrig_sec_counter #(
  parameter int unsigned WIDTH  = 13,
  parameter int unsigned TARGET = 0
) (
  input  logic clk1,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic hit
);

  localparam logic [WIDTH-1:0] TGT = WIDTH'(TARGET);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

  assign hit = (count == TGT);

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation cycle sequencer: mode arbitration, preset load, valve settle,
// run/pause on water level. Watchdog/FAULT present only with IRRIG_WATCHDOG_EN.
module irrigation_sequencer
  import irrig_pkg::*;
#(
  parameter int unsigned SETTLE_S = 3,
  parameter int unsigned WDOG_S   = 6000
) (
  input  logic                  clk1,
  input  logic                  reset,
  irrigation_sequencer_if.slave bus
);

  // Settle counter fires on the tick that completes the settle period.
  localparam int unsigned SETTLE_TGT = (SETTLE_S == 0) ? 0 : SETTLE_S - 1;

  state_t state, state_nx;
  sel_t   mode, mode_nx;
  logic   start_q, start_rise;
  logic   clear_nx;
  logic   settle_hit;
  logic   wdog_hit;
  logic   any_req;
  logic   valve_on_nx;

  assign any_req = bus.req_drip | bus.req_spray | bus.req_spec;

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      start_q    <= 1'b0;
      start_rise <= 1'b0;
    end else begin
      start_q    <= bus.start_btn;
      start_rise <= bus.start_btn & ~start_q;
    end
  end

  irrig_sec_counter #(
    .WIDTH (4),
    .TARGET(SETTLE_TGT)
  ) u_settle (
    .clk1 (clk1),
    .reset(reset),
    .clear(state != ST_SETTLE),
    .tick (bus.tick_1s && state == ST_SETTLE),
    .hit  (settle_hit)
  );

`ifdef IRRIG_WATCHDOG_EN
  irrig_sec_counter #(
    .WIDTH (WDOG_W),
    .TARGET(WDOG_S)
  ) u_wdog (
    .clk1 (clk1),
    .reset(reset),
    .clear(state == ST_LOAD),
    .tick (bus.tick_1s && (state == ST_RUN || state == ST_PAUSE)),
    .hit  (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      mode  <= SEL_NONE;
    end else begin
      state <= state_nx;
      mode  <= mode_nx;
    end
  end

  // Stop overrides everything; timer_zero outranks the watchdog in RUN.
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    clear_nx = 1'b0;
    if (state != ST_IDLE && bus.stop_btn) begin
      state_nx = ST_IDLE;
      mode_nx  = SEL_NONE;
      clear_nx = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_rise && any_req) begin
            state_nx = ST_LOAD;
            mode_nx  = pick_mode(bus.req_drip, bus.req_spray, bus.req_spec);
          end
        end
        ST_LOAD: begin
          state_nx = (SETTLE_S == 0) ? ST_RUN : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (SETTLE_S == 0 || (bus.tick_1s && settle_hit)) begin
            state_nx = ST_RUN;
          end
        end
        ST_RUN: begin
          if (bus.timer_zero)     state_nx = ST_DONE;
          else if (wdog_hit)      state_nx = ST_FAULT;
          else if (!bus.water_ok) state_nx = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (wdog_hit)          state_nx = ST_FAULT;
          else if (bus.water_ok) state_nx = ST_RUN;
        end
        ST_DONE: begin
          state_nx = ST_IDLE;
          mode_nx  = SEL_NONE;
        end
        ST_FAULT: begin
          state_nx = ST_FAULT;
        end
        default: begin
          state_nx = ST_IDLE;
          mode_nx  = SEL_NONE;
        end
      endcase
    end
  end

  assign valve_on_nx = (state_nx == ST_SETTLE) || (state_nx == ST_RUN) ||
                       (state_nx == ST_PAUSE);

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      bus.cnt_load    <= 1'b0;
      bus.cnt_clear   <= 1'b0;
      bus.cnt_sel     <= SEL_NONE;
      bus.cnt_en      <= 1'b0;
      bus.valve_drip  <= 1'b0;
      bus.valve_spray <= 1'b0;
      bus.pump        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      bus.cnt_load    <= (state_nx == ST_LOAD);
      bus.cnt_clear   <= clear_nx;
      bus.cnt_sel     <= mode_nx;
      bus.cnt_en      <= (state_nx == ST_RUN);
      bus.valve_drip  <= valve_on_nx && (mode_nx == SEL_DRIP);
      bus.valve_spray <= valve_on_nx && (mode_nx == SEL_SPRAY || mode_nx == SEL_SPEC);
      bus.pump        <= (state_nx == ST_SETTLE) || (state_nx == ST_RUN);
      bus.busy        <= (state_nx == ST_LOAD) || valve_on_nx;
      bus.done        <= (state_nx == ST_DONE);
    end
  end

`ifdef IRRIG_WATCHDOG_EN
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      bus.fault <= 1'b0;
    end else begin
      bus.fault <= (state_nx == ST_FAULT);
    end
  end
`else
  assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Directed scoreboard bench for irrigation_sequencer; expectations follow
// IRRIG_WATCHDOG_EN the same way the design does.
module tb_irrigation_sequencer;
  import irrig_pkg::*;

  localparam int S_IDLE   = 0;
  localparam int S_LOAD   = 1;
  localparam int S_SETTLE = 2;
  localparam int S_RUN    = 3;
  localparam int S_PAUSE  = 4;
  localparam int S_DONE   = 5;
  localparam int S_FAULT  = 6;
  localparam int S_CLEAR  = 7;

  string       tag_q[$];
  int          dut_q[$];
  logic [10:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  logic        clk1  = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] obs_a, obs_b;

  irrigation_sequencer_if ifa ();
  irrigation_sequencer_if ifb ();

  irrigation_sequencer #(.SETTLE_S(3), .WDOG_S(10)) dut_a (
    .clk1 (clk1),
    .reset(reset),
    .bus  (ifa.slave)
  );

  irrigation_sequencer #(.SETTLE_S(0), .WDOG_S(10)) dut_b (
    .clk1 (clk1),
    .reset(reset),
    .bus  (ifb.slave)
  );

  always #5 clk1 = ~clk1;

  assign obs_a = {ifa.cnt_load, ifa.cnt_clear, ifa.cnt_sel, ifa.cnt_en, ifa.valve_drip,
                  ifa.valve_spray, ifa.pump, ifa.busy, ifa.done, ifa.fault};
  assign obs_b = {ifb.cnt_load, ifb.cnt_clear, ifb.cnt_sel, ifb.cnt_en, ifb.valve_drip,
                  ifb.valve_spray, ifb.pump, ifb.busy, ifb.done, ifb.fault};

  // Bit order: load, clear, sel[1:0], en, valve_drip, valve_spray, pump, busy, done, fault.
  function automatic logic [10:0] exp_out(input int st, input logic [1:0] m);
    logic vd, vs;
    logic [10:0] v;
    vd = (m == 2'b01);
    vs = m[1];
    case (st)
      S_LOAD:   v = {1'b1, 1'b0, m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      S_SETTLE: v = {1'b0, 1'b0, m, 1'b0, vd,   vs,   1'b1, 1'b1, 1'b0, 1'b0};
      S_RUN:    v = {1'b0, 1'b0, m, 1'b1, vd,   vs,   1'b1, 1'b1, 1'b0, 1'b0};
      S_PAUSE:  v = {1'b0, 1'b0, m, 1'b0, vd,   vs,   1'b0, 1'b1, 1'b0, 1'b0};
      S_DONE:   v = {1'b0, 1'b0, m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      S_FAULT:  v = {1'b0, 1'b0, m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      S_CLEAR:  v = 11'b010_0000_0000;
      default:  v = '0;
    endcase
    return v;
  endfunction

  task automatic apply_stimulus(input string tag, input int dut, input int st,
                                input logic [1:0] m, input bit advance);
    tag_q.push_back(tag);
    dut_q.push_back(dut);
    exp_q.push_back(exp_out(st, m));
    if (advance) begin
      @(posedge clk1);
      #1;
    end
  endtask

  task automatic check_output();
    string       t;
    int          d;
    logic [10:0] ex;
    logic [10:0] o;
    t  = tag_q.pop_front();
    d  = dut_q.pop_front();
    ex = exp_q.pop_front();
    o  = (d == 0) ? obs_a : obs_b;
    checks++;
    assert (o === ex) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b required=%b", t, o, ex);
    end
  endtask

  task automatic step(input string tag, input int dut, input int st, input logic [1:0] m);
    apply_stimulus(tag, dut, st, m, 1'b1);
    check_output();
  endtask

  task automatic check_now(input string tag, input int dut, input int st, input logic [1:0] m);
    apply_stimulus(tag, dut, st, m, 1'b0);
    check_output();
  endtask

  task automatic tick_a(input string tag, input int st, input logic [1:0] m);
    ifa.tick_1s = 1'b1;
    step(tag, 0, st, m);
    ifa.tick_1s = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] m);
    ifa.req_drip  = (m == SEL_DRIP);
    ifa.req_spray = (m == SEL_SPRAY);
    ifa.req_spec  = (m == SEL_SPEC);
  endtask

  task automatic start_to_run(input string p, input logic [1:0] m);
    set_req(m);
    ifa.start_btn = 1'b1;
    step({p, "_edge"}, 0, S_IDLE, SEL_NONE);
    step({p, "_load"}, 0, S_LOAD, m);
    ifa.start_btn = 1'b0;
    step({p, "_settle"}, 0, S_SETTLE, m);
    tick_a({p, "_settle_t1"}, S_SETTLE, m);
    tick_a({p, "_settle_t2"}, S_SETTLE, m);
    tick_a({p, "_settle_t3"}, S_RUN, m);
  endtask

  task automatic full_cycle(input string p, input logic [1:0] m);
    set_req(m);
    ifa.start_btn = 1'b1;
    step({p, "_edge"}, 0, S_IDLE, SEL_NONE);
    step({p, "_load"}, 0, S_LOAD, m);
    step({p, "_settle"}, 0, S_SETTLE, m);
    tick_a({p, "_settle_t1"}, S_SETTLE, m);
    tick_a({p, "_settle_t2"}, S_SETTLE, m);
    tick_a({p, "_settle_t3"}, S_RUN, m);
    for (int k = 0; k < 5; k++) tick_a({p, "_run_tick"}, S_RUN, m);
    ifa.timer_zero = 1'b1;
    step({p, "_done"}, 0, S_DONE, m);
    ifa.timer_zero = 1'b0;
    step({p, "_idle"}, 0, S_IDLE, SEL_NONE);
    step({p, "_start_held"}, 0, S_IDLE, SEL_NONE);
    ifa.start_btn = 1'b0;
    set_req(SEL_NONE);
    step({p, "_idle_rel"}, 0, S_IDLE, SEL_NONE);
  endtask

  initial begin
    ifa.tick_1s = 1'b0; ifa.start_btn = 1'b0; ifa.stop_btn = 1'b0; ifa.req_drip = 1'b0;
    ifa.req_spray = 1'b0; ifa.req_spec = 1'b0; ifa.water_ok = 1'b1; ifa.timer_zero = 1'b0;
    ifb.tick_1s = 1'b0; ifb.start_btn = 1'b0; ifb.stop_btn = 1'b0; ifb.req_drip = 1'b0;
    ifb.req_spray = 1'b0; ifb.req_spec = 1'b0; ifb.water_ok = 1'b1; ifb.timer_zero = 1'b0;

    repeat (2) @(posedge clk1);
    #1;
    check_now("reset_a", 0, S_IDLE, SEL_NONE);
    check_now("reset_b", 1, S_IDLE, SEL_NONE);
    reset = 1'b0;
    step("post_reset", 0, S_IDLE, SEL_NONE);

    full_cycle("drip", SEL_DRIP);
    full_cycle("spray", SEL_SPRAY);
    full_cycle("spec", SEL_SPEC);

    // All requests at once: spec wins; then stop out of SETTLE.
    ifa.req_drip = 1'b1; ifa.req_spray = 1'b1; ifa.req_spec = 1'b1;
    ifa.start_btn = 1'b1;
    step("arb_edge", 0, S_IDLE, SEL_NONE);
    step("arb_load", 0, S_LOAD, SEL_SPEC);
    ifa.start_btn = 1'b0;
    step("arb_settle", 0, S_SETTLE, SEL_SPEC);
    ifa.stop_btn = 1'b1;
    step("stop_settle_clear", 0, S_CLEAR, SEL_NONE);
    ifa.stop_btn = 1'b0;
    set_req(SEL_NONE);
    step("stop_settle_idle", 0, S_IDLE, SEL_NONE);

    // Start edge with no request stays idle.
    ifa.start_btn = 1'b1;
    step("noreq_1", 0, S_IDLE, SEL_NONE);
    step("noreq_2", 0, S_IDLE, SEL_NONE);
    step("noreq_3", 0, S_IDLE, SEL_NONE);
    ifa.start_btn = 1'b0;
    step("noreq_4", 0, S_IDLE, SEL_NONE);

    // Low water with a tick landing in LOAD that must not count.
    set_req(SEL_DRIP);
    ifa.start_btn = 1'b1;
    step("lw_edge", 0, S_IDLE, SEL_NONE);
    step("lw_load", 0, S_LOAD, SEL_DRIP);
    ifa.start_btn = 1'b0;
    tick_a("lw_load_tick", S_SETTLE, SEL_DRIP);
    tick_a("lw_settle_t1", S_SETTLE, SEL_DRIP);
    tick_a("lw_settle_t2", S_SETTLE, SEL_DRIP);
    tick_a("lw_settle_t3", S_RUN, SEL_DRIP);
    tick_a("lw_run", S_RUN, SEL_DRIP);
    ifa.water_ok = 1'b0;
    step("lw_pause", 0, S_PAUSE, SEL_DRIP);
    ifa.timer_zero = 1'b1;
    step("lw_tz_in_pause", 0, S_PAUSE, SEL_DRIP);
    ifa.timer_zero = 1'b0;
    for (int k = 0; k < 4; k++) tick_a("lw_pause_tick", S_PAUSE, SEL_DRIP);
    ifa.water_ok = 1'b1;
    step("lw_resume", 0, S_RUN, SEL_DRIP);
    ifa.water_ok = 1'b0;
    ifa.timer_zero = 1'b1;
    step("lw_tz_low_water_done", 0, S_DONE, SEL_DRIP);
    ifa.water_ok = 1'b1;
    ifa.timer_zero = 1'b0;
    set_req(SEL_NONE);
    step("lw_idle", 0, S_IDLE, SEL_NONE);

    // Stop from RUN.
    start_to_run("srun", SEL_SPRAY);
    ifa.stop_btn = 1'b1;
    step("stop_run_clear", 0, S_CLEAR, SEL_NONE);
    ifa.stop_btn = 1'b0;
    set_req(SEL_NONE);
    step("stop_run_idle", 0, S_IDLE, SEL_NONE);

    // Request change after LOAD is ignored; then stop from PAUSE.
    start_to_run("spause", SEL_DRIP);
    ifa.req_drip = 1'b0;
    ifa.req_spec = 1'b1;
    tick_a("req_change_run", S_RUN, SEL_DRIP);
    ifa.water_ok = 1'b0;
    step("spause_pause", 0, S_PAUSE, SEL_DRIP);
    ifa.stop_btn = 1'b1;
    step("stop_pause_clear", 0, S_CLEAR, SEL_NONE);
    ifa.stop_btn = 1'b0;
    ifa.water_ok = 1'b1;
    set_req(SEL_NONE);
    step("stop_pause_idle", 0, S_IDLE, SEL_NONE);

    // Asynchronous reset in the middle of RUN.
    start_to_run("rst", SEL_SPEC);
    #2;
    reset = 1'b1;
    #1;
    check_now("async_reset_mid_run", 0, S_IDLE, SEL_NONE);
    @(posedge clk1);
    #1;
    reset = 1'b0;
    set_req(SEL_NONE);
    step("after_reset_idle", 0, S_IDLE, SEL_NONE);

    // Watchdog: ten ticks in RUN without timer_zero.
    start_to_run("wd", SEL_DRIP);
    for (int k = 0; k < 9; k++) tick_a("wd_run_tick", S_RUN, SEL_DRIP);
    ifa.tick_1s = 1'b1;
    @(posedge clk1);
    #1;
    ifa.tick_1s = 1'b0;
    repeat (2) @(posedge clk1);
    #1;
`ifdef IRRIG_WATCHDOG_EN
    step("wd_fault", 0, S_FAULT, SEL_DRIP);
    ifa.start_btn = 1'b1;
    step("wd_fault_start_1", 0, S_FAULT, SEL_DRIP);
    step("wd_fault_start_2", 0, S_FAULT, SEL_DRIP);
    ifa.start_btn = 1'b0;
    tick_a("wd_fault_tick", S_FAULT, SEL_DRIP);
`else
    step("wd_no_fault", 0, S_RUN, SEL_DRIP);
    ifa.start_btn = 1'b1;
    step("wd_no_fault_start", 0, S_RUN, SEL_DRIP);
    ifa.start_btn = 1'b0;
`endif
    ifa.stop_btn = 1'b1;
    step("wd_stop_clear", 0, S_CLEAR, SEL_NONE);
    ifa.stop_btn = 1'b0;
    set_req(SEL_NONE);
    step("wd_stop_idle", 0, S_IDLE, SEL_NONE);

    // Zero settle time: LOAD goes straight to RUN.
    ifb.req_drip = 1'b1;
    ifb.start_btn = 1'b1;
    step("s0_edge", 1, S_IDLE, SEL_NONE);
    step("s0_load", 1, S_LOAD, SEL_DRIP);
    step("s0_run", 1, S_RUN, SEL_DRIP);
    ifb.start_btn = 1'b0;
    ifb.timer_zero = 1'b1;
    step("s0_done", 1, S_DONE, SEL_DRIP);
    ifb.timer_zero = 1'b0;
    ifb.req_drip = 1'b0;
    step("s0_idle", 1, S_IDLE, SEL_NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irrigation_sequencer.md
# irrigation_sequencer

Control FSM that sequences the MM:SS irrigation countdown timer and the field actuators. It arbitrates mode requests (drip, sprinkler, specific program), loads the selected preset into the timer, opens the matching valve, and waits a settle period before gating the 1 s tick into the timer. It pauses on low water, ends the cycle on timer zero, and trips a fault on watchdog expiry. It sits between the push-button/sensor inputs and the countdown timer plus display path.

## Interface
- `SETTLE_S`, default 3: seconds between valve open and first counted tick, range 0–15.
- `WDOG_S`, default 6000: maximum seconds in RUN+PAUSE before FAULT, range 1–8191; the counter is 13 bits.
- `clk1`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick_1s`  in  1  one-`clk1`-cycle pulse per second, synchronous to `clk1`.
- `start_btn`  in  1  start button, already debounced and level; the block detects the rising edge internally.
- `stop_btn`  in  1  abort, level, highest priority.
- `req_drip`, `req_spray`, `req_spec`  in  1 each  mode request levels.
- `water_ok`  in  1  reservoir level sufficient.
- `timer_zero`  in  1  countdown reads 00:00.
- `cnt_load`  out  1  one-cycle preset load strobe to the timer.
- `cnt_clear`  out  1  one-cycle clear strobe to the timer.
- `cnt_sel`  out  2  preset select: 00 none, 01 drip, 10 spray, 11 specific.
- `cnt_en`  out  1  tick gate to the timer.
- `valve_drip`, `valve_spray`, `pump`  out  1 each  actuator drives.
- `busy`, `done`, `fault`  out  1 each  status.

## Operation
- States are IDLE, LOAD, SETTLE, RUN, PAUSE, DONE and FAULT. Reset forces IDLE and drives every output to 0.
- IDLE:
  - A `start_btn` rising edge with at least one request latches the mode and moves to LOAD.
  - Priority is spec > spray > drip.
  - With no request the edge is ignored.
- LOAD: `cnt_load`=1 for exactly one cycle, then SETTLE. `cnt_sel` holds the latched mode from LOAD until the next return to IDLE.
- SETTLE:
  - The valve is on: drip → `valve_drip`; spray or spec → `valve_spray`. `pump`=1 and `cnt_en`=0.
  - Counts `SETTLE_S` ticks, then RUN.
  - With `SETTLE_S`=0, goes to RUN on the next cycle.
- RUN: valve, `pump` and `cnt_en` are all 1.
  - `timer_zero` → DONE.
  - Otherwise, `water_ok`=0 → PAUSE.
- PAUSE: valve stays on; `pump`=0 and `cnt_en`=0. `water_ok`=1 → RUN.
- DONE: all actuators off and `done`=1 for one cycle, then IDLE.
- FAULT: all actuators off and `fault`=1. Only `stop_btn` or `reset` leaves FAULT, and both go to IDLE.
- `stop_btn`=1 in any state except IDLE:
  - Next state is IDLE, with a one-cycle `cnt_clear` pulse.
  - Actuators are off from the next cycle.
  - When leaving FAULT, `stop_btn` also pulses `cnt_clear`.
- `busy`=1 in LOAD, SETTLE, RUN and PAUSE.
- Boundary rules:
  - `timer_zero` is ignored outside RUN.
  - `timer_zero` together with `water_ok`=0 → DONE.
  - `stop_btn` overrides every other transition.
  - Ticks arriving in LOAD are ignored.
  - Request changes after LOAD have no effect.
  - `start_btn` held through DONE does not restart; a new rising edge is needed.

## Timing
- All outputs are registered Moore outputs, so state changes appear one cycle after the causing input is sampled.
- Start edge to `cnt_load`: 2 cycles (edge-detect register, then LOAD).
- `cnt_en` asserts on the cycle after the `SETTLE_S`-th tick is sampled in SETTLE.
- Watchdog:
  - Increments on `tick_1s` in RUN and PAUSE.
  - Clears on entry to LOAD.
  - When the count equals `WDOG_S`, next state is FAULT.
  - If a watchdog hit and `timer_zero` land in the same cycle, DONE wins.
  - The counter saturates and never wraps.
- Asynchronous reset mid-cycle drops every actuator immediately.

## Configuration
- `IRRIG_WATCHDOG_EN` defined: watchdog counter and the FAULT state are present, as described above.
- `IRRIG_WATCHDOG_EN` undefined:
  - No watchdog logic.
  - FAULT is unreachable and `fault` is tied to 0.
  - `WDOG_S` is ignored.

## Structure
- Package `irrig_pkg` holds:
  - the state enum;
  - `cnt_sel` codes `SEL_NONE`, `SEL_DRIP`, `SEL_SPRAY` and `SEL_SPEC`;
  - the width constant `WDOG_W`=13.
- One sub-module, `irrig_sec_counter`: a tick-driven up counter with sync clear, saturate and compare-equal. It is instanced for settle, and a second time under `IRRIG_WATCHDOG_EN` for the watchdog.

## Test plan
- Drip, spray and spec each run a full cycle:
  - Stimulus: `req_drip`, start edge, `SETTLE_S`=3, `water_ok`=1, then assert `timer_zero` after 5 ticks.
  - Required response: `cnt_load` pulses once with `cnt_sel`=01; `valve_drip`=1 from SETTLE; `cnt_en`=1 after 3 ticks; `done` pulses once; all outputs return to 0.
  - Repeat with `req_spray` → `cnt_sel`=10, `valve_spray`=1, and with `req_spec` → `cnt_sel`=11, `valve_spray`=1.
- Arbitration: `req_drip`=`req_spray`=`req_spec`=1 and a start edge → `cnt_sel`=11 and `valve_spray`=1. With no request, a start edge keeps IDLE and `busy`=0.
- Low water: drop `water_ok` for 4 ticks during RUN → `pump`=0, `cnt_en`=0, valve held; restore → RUN resumes with `cnt_en`=1. `timer_zero` with `water_ok`=0 in the same cycle → DONE.
- Stop: `stop_btn` in SETTLE, RUN and PAUSE → one `cnt_clear` pulse, actuators 0 the next cycle, IDLE. Asynchronous `reset` pulse mid-RUN → all outputs 0 immediately.
- Watchdog with `IRRIG_WATCHDOG_EN`:
  - `WDOG_S`=10 and `timer_zero` never asserted → FAULT after the 10th tick, `fault`=1, start edges ignored; `stop_btn` → IDLE with a `cnt_clear` pulse.
  - Without the macro, the same stimulus keeps RUN and `fault`=0.
- `SETTLE_S`=0: start edge → LOAD, then RUN the next cycle, with `cnt_en`=1 three cycles after the start edge.
